// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

   // Sequencer state: waiting for operands, adding one bit per cycle,
   // presenting the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder, purely combinational; the only arithmetic in the sequencer.
// Latency: 0 cycles.
// Backpressure: none (no state).
// Ports: x, y, ci -> s (sum bit), co (carry out).
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks a WIDTH-bit pair LSB first.
// Latency: WIDTH cycles from operand accept to out_valid; initiation interval WIDTH+2.
// Backpressure: result is held in DONE until out_ready; operands only taken in IDLE.
// Ports: clk/rst_n; in_valid/in_ready with a, b, cin; out_valid/out_ready with
//        sum, cout; busy while an operation is in flight (RUN or DONE).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   sa_state_t        state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   fa_cell u_fa (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // The handshake flags are registered alongside the state so they are pure
   // functions of it; nothing from in_valid/out_ready reaches them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  carry    <= cin;
                  sum_sr   <= '0;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               // Sum bits enter at the top so the LSB lands at bit 0 after WIDTH shifts.
               sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
               carry  <= fa_co;
               cnt    <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Mask the partially built sum while RUN is shifting so only a complete
   // result is ever visible on the output.
   assign sum  = out_valid ? sum_sr : '0;
   assign cout = out_valid & carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [7:0] a, b, sum;

   logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
   logic [1:0] a2, b2, sum2;

   int checks   = 0;
   int failures = 0;
   logic [8:0] sb[$];

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .busy(busy2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one operand pair, expect the result WIDTH cycles later, optionally
   // hold the result under backpressure for 'hold' cycles, then release it.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input int hold, input string tag);
      logic [8:0] exp;
      int lat;
      @(negedge clk);
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = (hold == 0);
      sb.push_back(9'(ta) + 9'(tb_) + 9'(tc));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid) begin
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd8);
      exp = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_hold_sum"}, 32'(sum), 32'(exp[7:0]));
         chk({tag, "_hold_cout"}, 32'(cout), 32'(exp[8]));
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
         chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
         in_valid = (i == 2);
         a = ~ta;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(exp[8]));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int lat2, acc, res, cyc;
      logic fire_in, fire_out;
      logic [8:0] e;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'h0F, 8'h01, 1'b0, 0, "add_0f_01");
      run_op(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
      run_op(8'hFF, 8'hFF, 1'b1, 0, "add_ff_ff_c");
      run_op(8'h3C, 8'h5A, 1'b0, 5, "bp_3c_5a");

      // Reset in the middle of RUN, after the third bit edge.
      @(negedge clk);
      a = 8'h55; b = 8'h0A; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h01, 8'h01, 1'b0, 0, "post_rst");

      // Streaming: in_valid always high, out_ready random.
      acc = 0; res = 0; cyc = 0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      while ((acc < 100 || res < acc) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'($urandom_range(0, 1));
         if (acc >= 100) in_valid = 1'b0;
         fire_in  = in_valid && in_ready;
         fire_out = out_valid && out_ready;
         if (fire_out) begin
            if (sb.size() == 0) begin
               chk("stream_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("stream_sum", 32'(sum), 32'(e[7:0]));
               chk("stream_cout", 32'(cout), 32'(e[8]));
            end
            res++;
         end
         if (fire_in) begin
            sb.push_back(9'(a) + 9'(b) + 9'(cin));
            acc++;
         end
         @(posedge clk); #1;
         if (fire_in) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("stream_accepts", 32'(acc), 32'd100);
      chk("stream_results", 32'(res), 32'd100);
      chk("stream_sb_empty", 32'(sb.size()), 32'd0);

      // Narrowest build: 3 + 3 + 1 = 7 -> sum 2'b11, cout 1.
      @(negedge clk);
      chk("w2_in_ready", 32'(in_ready2), 32'd1);
      a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1; in_valid2 = 1'b1; out_ready2 = 1'b0;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat2 = 0;
      while (!out_valid2 && lat2 < 20) begin
         @(posedge clk); #1;
         lat2++;
      end
      chk("w2_latency", 32'(lat2), 32'd2);
      chk("w2_sum", 32'(sum2), 32'd3);
      chk("w2_cout", 32'(cout2), 32'd1);
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      chk("w2_in_ready_after", 32'(in_ready2), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
